pio_cmd_loader: RTL and testbench

- Upstream configuration sequencer for the pio block: converts a host byte stream (UART/SPI receiver) into single-cycle action/index/mindex/din strobes on the pio host interface.
- Lets a remote host load instructions, set wrap, divider and pin groups, enable machines, and inject immediate instructions at runtime without a hard-coded testbench sequence.
- Includes frame-level error handling: invalid action, inter-byte timeout, and optional checksum.

---
 rtl/pio_cmd_loader.sv | 178 +++++++++++++++++
 tb/tb_pio_cmd_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_loader.sv
// Byte-stream to pio host-interface command loader: 6-byte frames become one-cycle action strobes.
// Define PIO_CMD_LOADER_CSUM_EN to append a 7th XOR checksum byte to every frame.
module pio_cmd_loader #(
  parameter int TIMEOUT    = 25000,
  parameter int MAX_ACTION = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] frame_cnt
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_IDX,
    S_D0,
    S_D1,
    S_D2,
    S_D3,
`ifdef PIO_CMD_LOADER_CSUM_EN
    S_CS,
`endif
    S_ISSUE,
    S_GAP
  } state_t;

  state_t        state;
  logic [5:0]    op_q;
  logic [4:0]    idx_q;
  logic [31:0]   din_q;
  logic [CW-1:0] idle_cnt;
  logic          in_frame;
  logic          xfer;
  logic          action_ok;
  logic          timeout_hit;
  logic          err_set;
`ifdef PIO_CMD_LOADER_CSUM_EN
  logic [7:0]    csum_q;
`endif

  assign xfer      = in_valid & in_ready;
  assign busy      = (state != S_IDLE);
  assign action_ok = (op_q[3:0] <= 4'(MAX_ACTION));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_ready = 1'b0;
    in_frame = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_IDX, S_D0, S_D1, S_D2, S_D3
`ifdef PIO_CMD_LOADER_CSUM_EN
      , S_CS
`endif
      : begin
        in_ready = 1'b1;
        in_frame = 1'b1;
      end
      default: ;
    endcase
  end

  // Idle gaps inside a frame abort it; the count restarts on every accepted byte.
  assign timeout_hit = in_frame && !xfer && (idle_cnt == TO_LAST);

  always_comb begin
    err_set = timeout_hit;
    if (state == S_ISSUE && !action_ok) err_set = 1'b1;
`ifdef PIO_CMD_LOADER_CSUM_EN
    if (state == S_CS && xfer && in_data != csum_q) err_set = 1'b1;
`endif
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      idx_q     <= '0;
      din_q     <= '0;
      idle_cnt  <= '0;
      action    <= '0;
      index     <= '0;
      mindex    <= '0;
      din       <= '0;
      err       <= 1'b0;
      frame_cnt <= '0;
`ifdef PIO_CMD_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      action <= '0;
      err    <= err_set | (err & ~err_clr);

      if (xfer || !in_frame) idle_cnt <= '0;
      else                   idle_cnt <= idle_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (xfer) begin
            op_q  <= in_data[5:0];
            state <= S_IDX;
`ifdef PIO_CMD_LOADER_CSUM_EN
            csum_q <= in_data;
`endif
          end
        end
        S_IDX: begin
          if (xfer) begin
            idx_q <= in_data[4:0];
            state <= S_D0;
`ifdef PIO_CMD_LOADER_CSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end
        S_D0, S_D1, S_D2, S_D3: begin
          if (xfer) begin
            // Little-endian: the first data byte ends up in din[7:0].
            din_q <= {in_data, din_q[31:8]};
`ifdef PIO_CMD_LOADER_CSUM_EN
            csum_q <= csum_q ^ in_data;
`endif
            case (state)
              S_D0:    state <= S_D1;
              S_D1:    state <= S_D2;
              S_D2:    state <= S_D3;
`ifdef PIO_CMD_LOADER_CSUM_EN
              default: state <= S_CS;
`else
              default: state <= S_ISSUE;
`endif
            endcase
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end
`ifdef PIO_CMD_LOADER_CSUM_EN
        S_CS: begin
          if (xfer) begin
            state <= (in_data == csum_q) ? S_ISSUE : S_IDLE;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end
`endif
        S_ISSUE: begin
          // Rejected codes leave the host-side outputs untouched.
          if (action_ok) begin
            action    <= op_q[3:0];
            mindex    <= op_q[5:4];
            index     <= idx_q;
            din       <= din_q;
            frame_cnt <= frame_cnt + 16'd1;
          end
          state <= S_GAP;
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_loader.sv
// Directed self-checking bench for pio_cmd_loader (short TIMEOUT for speed).
module tb_pio_cmd_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        err_clr = 1'b0;
  logic        in_ready;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy;
  logic        err;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  pio_cmd_loader #(.TIMEOUT(TO), .MAX_ACTION(12)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .action    (action),
    .index     (index),
    .mindex    (mindex),
    .din       (din),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Issue log: every cycle with a non-NONE action is recorded.
  int          log_n = 0;
  int          stalls = 0;
  int          dbl = 0;
  logic        prev_nz = 1'b0;
  logic [3:0]  log_act [8];
  logic [4:0]  log_idx [8];
  logic [1:0]  log_mi  [8];
  logic [31:0] log_din [8];

  always @(negedge clk) begin
    if (action != 4'd0) begin
      if (log_n < 8) begin
        log_act[log_n] = action;
        log_idx[log_n] = index;
        log_mi[log_n]  = mindex;
        log_din[log_n] = din;
      end
      log_n = log_n + 1;
      if (prev_nz) dbl = dbl + 1;
    end
    prev_nz = (action != 4'd0);
  end

  always @(posedge clk) begin
    if (in_valid && !in_ready) stalls = stalls + 1;
  end

  task automatic clear_log();
    log_n = 0;
    stalls = 0;
    dbl = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_byte %h: in_ready=%b, required 1 within 40 cycles", b, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                            input bit bad_cs);
    logic [7:0] cs;
    cs = b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5;
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
    send_byte(b5);
`ifdef PIO_CMD_LOADER_CSUM_EN
    send_byte(bad_cs ? (cs ^ 8'h5A) : cs);
`else
    if (bad_cs) cs = ~cs;
`endif
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr: err=%b, required 0", err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({action, index, mindex, din, err, frame_cnt, busy, in_ready} !==
        {4'd0, 5'd0, 2'd0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: act=%0d idx=%0d mi=%0d din=%h err=%b cnt=%0d busy=%b rdy=%b, required zeros with rdy=1",
               action, index, mindex, din, err, frame_cnt, busy, in_ready);
    end
  endtask

  task automatic test_instr_load();
    clear_log();
    send_frame(8'h01, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h00, 1'b0);
    in_valid = 1'b0;
    tests++;
    if ({action, in_ready, busy} !== {4'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL instr_issue_state: act=%0d rdy=%b busy=%b, required 0/0/1", action, in_ready, busy);
    end
    @(negedge clk);
    tests++;
    if ({action, index, mindex} !== {4'd1, 5'd0, 2'd0}) begin
      fails++;
      $display("FAIL instr_action: act=%0d idx=%0d mi=%0d, required 1/0/0", action, index, mindex);
    end
    tests++;
    if (din !== 32'h0000E001) begin
      fails++;
      $display("FAIL instr_din: din=%h, required 0000e001", din);
    end
    tests++;
    if ({frame_cnt, err} !== {16'd1, 1'b0}) begin
      fails++;
      $display("FAIL instr_cnt: cnt=%0d err=%b, required 1/0", frame_cnt, err);
    end
    @(negedge clk);
    tests++;
    if ({action, in_ready, log_n} !== {4'd0, 1'b1, 32'd1}) begin
      fails++;
      $display("FAIL instr_single_pulse: act=%0d rdy=%b pulses=%0d, required 0/1/1", action, in_ready, log_n);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_frame(8'h07, 8'h00, 8'h80, 8'h02, 8'h00, 8'h00, 1'b0);
    send_frame(8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (stalls !== 2) begin
      fails++;
      $display("FAIL b2b_stalls: stall cycles=%0d, required 2", stalls);
    end
    tests++;
    if (log_n !== 2 || log_act[0] !== 4'd7 || log_act[1] !== 4'd5) begin
      fails++;
      $display("FAIL b2b_actions: pulses=%0d first=%0d second=%0d, required 2/7/5", log_n, log_act[0], log_act[1]);
    end
    tests++;
    if (log_din[0] !== 32'h00000280 || log_din[1] !== 32'h04000000) begin
      fails++;
      $display("FAIL b2b_din: first=%h second=%h, required 00000280/04000000", log_din[0], log_din[1]);
    end
    tests++;
    if (dbl !== 0 || frame_cnt !== 16'd3) begin
      fails++;
      $display("FAIL b2b_gap: adjacent pulses=%0d cnt=%0d, required 0/3", dbl, frame_cnt);
    end
  endtask

  task automatic test_boundary_codes();
    clear_log();
    send_frame(8'h00, 8'h07, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if ({log_n, frame_cnt, index, din, err} !== {32'd0, 16'd4, 5'd7, 32'hDDCCBBAA, 1'b0}) begin
      fails++;
      $display("FAIL none_frame: pulses=%0d cnt=%0d idx=%0d din=%h err=%b, required 0/4/7/ddccbbaa/0",
               log_n, frame_cnt, index, din, err);
    end
    send_frame(8'hCC, 8'h1F, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (log_n !== 1 || log_act[0] !== 4'd12 || log_mi[0] !== 2'd0 || log_idx[0] !== 5'd31 || frame_cnt !== 16'd5) begin
      fails++;
      $display("FAIL max_action: pulses=%0d act=%0d mi=%0d idx=%0d cnt=%0d, required 1/12/0/31/5",
               log_n, log_act[0], log_mi[0], log_idx[0], frame_cnt);
    end
    send_frame(8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if ({log_n, err, frame_cnt} !== {32'd1, 1'b1, 16'd5}) begin
      fails++;
      $display("FAIL max_plus_one: pulses=%0d err=%b cnt=%0d, required 1/1/5", log_n, err, frame_cnt);
    end
    pulse_err_clr();
  endtask

  task automatic test_invalid_action();
    clear_log();
    send_frame(8'h0F, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if ({log_n, err, frame_cnt, busy} !== {32'd0, 1'b1, 16'd5, 1'b0}) begin
      fails++;
      $display("FAIL invalid_action: pulses=%0d err=%b cnt=%0d busy=%b, required 0/1/5/0", log_n, err, frame_cnt, busy);
    end
    pulse_err_clr();
  endtask

  task automatic test_timeout();
    clear_log();
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    in_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    tests++;
    if ({busy, err} !== {1'b1, 1'b0}) begin
      fails++;
      $display("FAIL timeout_early: busy=%b err=%b one cycle before limit, required 1/0", busy, err);
    end
    @(negedge clk);
    tests++;
    if ({busy, err, in_ready} !== {1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL timeout_abort: busy=%b err=%b rdy=%b, required 0/1/1", busy, err, in_ready);
    end
    pulse_err_clr();
    send_frame(8'h13, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (log_n !== 1 || {log_act[0], log_mi[0], log_idx[0], log_din[0]} !== {4'd3, 2'd1, 5'd5, 32'h12345678} ||
        frame_cnt !== 16'd6 || log_n > 1 && log_n < 0) begin
      fails++;
      $display("FAIL timeout_recover: pulses=%0d act=%0d mi=%0d idx=%0d din=%h cnt=%0d, required 1/3/1/5/12345678/6",
               log_n, log_act[0], log_mi[0], log_idx[0], log_din[0], frame_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    send_byte(8'h09);
    send_byte(8'h02);
    send_byte(8'hFF);
    send_byte(8'hFF);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({action, index, mindex, din, err, frame_cnt, busy} !== {4'd0, 5'd0, 2'd0, 32'd0, 1'b0, 16'd0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: idx=%0d mi=%0d din=%h cnt=%0d busy=%b, required zeros", index, mindex, din, frame_cnt, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: rdy=%b, required 1", in_ready);
    end
    send_frame(8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (log_n !== 1 || {log_act[0], log_mi[0], log_din[0]} !== {4'd2, 2'd0, 32'd1} || frame_cnt !== 16'd1) begin
      fails++;
      $display("FAIL pend_after_reset: pulses=%0d act=%0d mi=%0d din=%h cnt=%0d, required 1/2/0/00000001/1",
               log_n, log_act[0], log_mi[0], log_din[0], frame_cnt);
    end
  endtask

`ifdef PIO_CMD_LOADER_CSUM_EN
  task automatic test_csum();
    clear_log();
    send_frame(8'h06, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (log_n !== 1 || log_act[0] !== 4'd6 || log_din[0] !== 32'h40302010 || frame_cnt !== 16'd2) begin
      fails++;
      $display("FAIL csum_good: pulses=%0d act=%0d din=%h cnt=%0d, required 1/6/40302010/2",
               log_n, log_act[0], log_din[0], frame_cnt);
    end
    send_frame(8'h06, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL csum_bad_idle: busy=%b right after B6, required 0", busy);
    end
    repeat (4) @(negedge clk);
    tests++;
    if ({log_n, err, frame_cnt} !== {32'd1, 1'b1, 16'd2}) begin
      fails++;
      $display("FAIL csum_bad: pulses=%0d err=%b cnt=%0d, required 1/1/2", log_n, err, frame_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_instr_load();
    test_back_to_back();
    test_boundary_codes();
    test_invalid_action();
    test_timeout();
    test_reset_mid_frame();
`ifdef PIO_CMD_LOADER_CSUM_EN
    test_csum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
